xge_rx_pkt_reader: RTL and testbench
====================================

Name: xge_rx_pkt_reader

Overview:
- Downstream consumer of the xge_mac POS-L3 receive interface.
- Watches pkt_rx_avail, drives pkt_rx_ren, tracks frame boundaries and buffers received words in an internal FIFO.
- Presents frames on a valid/ready stream with per-frame byte length and error flag, and keeps receive statistics counters.
- Sits between the MAC core and the bench-side scoreboard/consumer logic.

Parameters:
FIFO_DEPTH, 8, output FIFO entries; power of two, >= 4
LEN_W, 16, width of out_len (saturating)

Ports:
clk_156m25  in  1  core clock
reset_156m25_n  in  1  asynchronous active-low reset
pkt_rx_avail  in  1  MAC has a frame available
pkt_rx_data  in  64  MAC receive data
pkt_rx_sop  in  1  start of packet, qualified by pkt_rx_val
pkt_rx_eop  in  1  end of packet, qualified by pkt_rx_val
pkt_rx_val  in  1  data word valid
pkt_rx_err  in  1  frame error, meaningful on eop word
pkt_rx_mod  in  3  valid bytes in eop word; 0 means 8
pkt_rx_ren  out  1  read enable to MAC (registered)
out_valid  out  1  stream word valid
out_ready  in  1  consumer accepts word
out_data  out  64  word data
out_sop  out  1  first word of frame
out_eop  out  1  last word of frame
out_mod  out  3  copy of pkt_rx_mod on eop word, else 0
out_err  out  1  pkt_rx_err on eop word, else 0
out_len  out  LEN_W  frame byte count on eop word, else 0
clear_stats  in  1  synchronous clear of statistics
stat_frames  out  32  frames completed (eop accepted)
stat_err_frames  out  32  completed frames with pkt_rx_err
stat_bytes  out  32  sum of out_len of completed frames, wraps
stat_proto_err  out  16  protocol violations, saturates at 16'hFFFF

Behaviour:
- Clock and reset: one clock, clk_156m25; reset_156m25_n is asynchronous and active-low.
- Reset values: pkt_rx_ren=0, out_valid=0, all out_* fields=0, all stat_*=0, FIFO empty, FSM=IDLE, in_frame=0.
- Reset mid-frame discards the partial frame and all buffered words.
- space_ok = (FIFO occupancy at start of cycle) <= FIFO_DEPTH-2. This covers the word already in flight from the previous ren plus the word from the current ren.
- Read FSM, IDLE:
  - next state = READ when pkt_rx_avail && space_ok.
- Read FSM, READ:
  - stays in READ until a word with pkt_rx_val && pkt_rx_eop is accepted, then IDLE.
- pkt_rx_ren is registered: pkt_rx_ren(t+1) = (next_state==READ) && space_ok(t).
  - First ren is therefore 1 cycle after avail is seen.
  - ren drops the cycle after the eop word.
- Frame tracker runs independently of the FSM, on every pkt_rx_val word:
  - sop && !in_frame: start frame; word count=1; write word; in_frame=1.
  - sop && in_frame: proto_err++; restart count at 1; write word with out_sop=1. The previous frame gets no eop and no stats.
  - !sop && in_frame: count++; write word.
  - !sop && !in_frame: proto_err++; drop word.
  - sop && eop together is a legal single-word frame.
  - On an eop word (while in_frame or with sop):
    - len = 8*(count-1) + (mod==0 ? 8 : mod), saturating at 2^LEN_W-1.
    - in_frame=0.
- Overflow: pkt_rx_val with a full FIFO drops the word and increments proto_err. This is unreachable if the space rule holds, and is checked by assertion.
- FIFO output:
  - A word written at cycle t is visible on out_* no earlier than t+1.
  - out_valid stays high and out_* stay stable until out_ready.
  - Simultaneous read and write of a full FIFO is allowed.
- Stats update one cycle after eop word acceptance into the FIFO, not on output handshake:
  - stat_frames++.
  - stat_err_frames++ if pkt_rx_err.
  - stat_bytes += len.
- clear_stats zeroes all stat_* next cycle; clear wins over a same-cycle increment.
- stat_proto_err saturates; the other counters wrap modulo 2^32.

Test Plan:
- Single 64-byte frame (8 words, eop mod=0), out_ready=1 -> ren high for the frame; 8 out words, sop on 1st, eop on 8th; out_len=64, out_err=0; stat_frames=1, stat_bytes=64.
- 61-byte frame (eop mod=5) with pkt_rx_err=1 -> out_len=61, out_err=1 on eop; stat_err_frames=1.
- out_ready=0 throughout a 20-word frame, FIFO_DEPTH=8 -> ren deasserts once occupancy >6; no word lost; after out_ready=1 all 20 words arrive in order, out_len=160.
- pkt_rx_val without sop while idle, then sop-in-frame -> stat_proto_err=2; stray word absent from the output; second frame delivered with correct length.
- Back-to-back frames, avail held high, 1-word frame (sop&eop, mod=3) then 2-word frame -> lengths 3 and 16; stat_frames=2, stat_bytes=19.
- Assert reset_156m25_n mid-frame, then clear_stats pulsed in the same cycle as an eop -> outputs and stats 0 immediately; after the clear, stats remain 0.

Source files
------------

// File: rtl/xge_rx_pkt_reader.sv
// Receive-side reader for the xge_mac POS-L3 packet interface. It pulls frames out of the MAC,
// buffers the words in a small FIFO and replays them as a valid/ready stream with statistics.
module xge_rx_pkt_reader #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             pkt_rx_avail,
  input  logic [63:0]      pkt_rx_data,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic             pkt_rx_val,
  input  logic             pkt_rx_err,
  input  logic [2:0]       pkt_rx_mod,
  output logic             pkt_rx_ren,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [2:0]       out_mod,
  output logic             out_err,
  output logic [LEN_W-1:0] out_len,
  input  logic             clear_stats,
  output logic [31:0]      stat_frames,
  output logic [31:0]      stat_err_frames,
  output logic [31:0]      stat_bytes,
  output logic [15:0]      stat_proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 64 + 1 + 1 + 3 + 1 + LEN_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_e;

  rd_state_e        state_q, state_d;
  logic             ren_q, ren_d;
  logic             space_ok;

  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic             fifo_full;
  logic             wr_req, wr_fire, rd_fire, overflow;
  logic [EW-1:0]    wr_entry, head;

  logic             in_frame_q, in_frame_d;
  logic [LEN_W-1:0] wcnt_q, wcnt_d, cnt_new;
  logic             proto_ev, eop_ev, frame_done;
  logic [3:0]       eop_bytes;
  logic [LEN_W+3:0] len_wide;
  logic [LEN_W-1:0] frame_len;

  logic [31:0]      frames_q, frames_d;
  logic [31:0]      err_frames_q, err_frames_d;
  logic [31:0]      bytes_q, bytes_d;
  logic [15:0]      proto_q, proto_d;

  // Two slots of headroom: the word arriving under the current ren plus the one
  // requested by the ren being registered now.
  assign space_ok = (occ_q <= CW'(FIFO_DEPTH - 2));

  // Read FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pkt_rx_avail && space_ok) state_d = ST_READ;
      ST_READ: if (pkt_rx_val && pkt_rx_eop) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read FSM: output logic feeding the registered read enable.
  always_comb begin
    ren_d = (state_d == ST_READ) && space_ok;
  end

  assign pkt_rx_ren = ren_q;

  // Frame tracker, independent of the FSM: follows sop/eop on every valid word.
  always_comb begin
    in_frame_d = in_frame_q;
    wcnt_d     = wcnt_q;
    cnt_new    = wcnt_q;
    wr_req     = 1'b0;
    proto_ev   = 1'b0;
    eop_ev     = 1'b0;
    if (pkt_rx_val) begin
      if (pkt_rx_sop) begin
        proto_ev = in_frame_q;
        cnt_new  = LEN_W'(1);
        wr_req   = 1'b1;
      end else if (in_frame_q) begin
        cnt_new  = (wcnt_q == '1) ? wcnt_q : wcnt_q + LEN_W'(1);
        wr_req   = 1'b1;
      end else begin
        proto_ev = 1'b1;
      end
      if (wr_req) begin
        wcnt_d     = cnt_new;
        in_frame_d = !pkt_rx_eop;
        eop_ev     = pkt_rx_eop;
      end
    end
  end

  // Byte length of the frame closed by the current word, saturating.
  always_comb begin
    eop_bytes = (pkt_rx_mod == 3'd0) ? 4'd8 : {1'b0, pkt_rx_mod};
    len_wide  = ({4'b0000, cnt_new - LEN_W'(1)} << 3) + (LEN_W + 4)'(eop_bytes);
    frame_len = (|len_wide[LEN_W+3:LEN_W]) ? '1 : len_wide[LEN_W-1:0];
  end

  assign wr_entry = {pkt_rx_data, pkt_rx_sop, pkt_rx_eop,
                     pkt_rx_eop ? pkt_rx_mod : 3'd0,
                     pkt_rx_eop ? pkt_rx_err : 1'b0,
                     pkt_rx_eop ? frame_len  : {LEN_W{1'b0}}};

  // Stream handshake: a word transfers on a clock edge where out_valid && out_ready;
  // while out_valid is high and out_ready low the presented word is held unchanged.
  assign out_valid = (occ_q != '0);
  assign rd_fire   = out_valid && out_ready;
  assign fifo_full = (occ_q == CW'(FIFO_DEPTH));
  assign wr_fire   = wr_req && (!fifo_full || rd_fire);
  assign overflow  = wr_req && fifo_full && !rd_fire;
  assign frame_done = eop_ev && wr_fire;

  always_comb begin
    wr_ptr_d = wr_fire ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
    occ_d    = occ_q + CW'(wr_fire) - CW'(rd_fire);
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    {out_data, out_sop, out_eop, out_mod, out_err, out_len} = out_valid ? head : '0;
  end

  // Statistics: clear has priority over any same-cycle increment.
  always_comb begin
    frames_d     = frames_q;
    err_frames_d = err_frames_q;
    bytes_d      = bytes_q;
    proto_d      = proto_q;
    if (clear_stats) begin
      frames_d     = '0;
      err_frames_d = '0;
      bytes_d      = '0;
      proto_d      = '0;
    end else begin
      if (frame_done) begin
        frames_d = frames_q + 32'd1;
        bytes_d  = bytes_q + 32'(frame_len);
        if (pkt_rx_err) err_frames_d = err_frames_q + 32'd1;
      end
      if ((proto_ev || overflow) && (proto_q != 16'hFFFF)) proto_d = proto_q + 16'd1;
    end
  end

  assign stat_frames     = frames_q;
  assign stat_err_frames = err_frames_q;
  assign stat_bytes      = bytes_q;
  assign stat_proto_err  = proto_q;

  // Read FSM: state register together with the rest of the control state.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q      <= ST_IDLE;
      ren_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      in_frame_q   <= 1'b0;
      wcnt_q       <= '0;
      frames_q     <= '0;
      err_frames_q <= '0;
      bytes_q      <= '0;
      proto_q      <= '0;
    end else begin
      state_q      <= state_d;
      ren_q        <= ren_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      in_frame_q   <= in_frame_d;
      wcnt_q       <= wcnt_d;
      frames_q     <= frames_d;
      err_frames_q <= err_frames_d;
      bytes_q      <= bytes_d;
      proto_q      <= proto_d;
    end
  end

  // Storage needs no reset: nothing is visible until the occupancy says so.
  always_ff @(posedge clk_156m25) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_entry;
  end

  // The headroom rule on ren should make a write into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk_156m25) disable iff (!reset_156m25_n) !overflow);

endmodule

// File: tb/tb_xge_rx_pkt_reader.sv
// Bench for xge_rx_pkt_reader: a MAC model honouring ren, a frame-level reference model
// feeding an expected-word queue, table-driven frames, corner sequences and a random phase.
module tb_xge_rx_pkt_reader;

  localparam int FIFO_DEPTH = 8;
  localparam int LEN_W      = 16;
  localparam int EW         = 64 + 1 + 1 + 3 + 1 + LEN_W;

  logic             clk_156m25 = 1'b0;
  logic             reset_156m25_n = 1'b0;
  logic             pkt_rx_avail = 1'b0;
  logic [63:0]      pkt_rx_data = '0;
  logic             pkt_rx_sop = 1'b0;
  logic             pkt_rx_eop = 1'b0;
  logic             pkt_rx_val = 1'b0;
  logic             pkt_rx_err = 1'b0;
  logic [2:0]       pkt_rx_mod = '0;
  logic             pkt_rx_ren;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out_data;
  logic             out_sop;
  logic             out_eop;
  logic [2:0]       out_mod;
  logic             out_err;
  logic [LEN_W-1:0] out_len;
  logic             clear_stats = 1'b0;
  logic [31:0]      stat_frames;
  logic [31:0]      stat_err_frames;
  logic [31:0]      stat_bytes;
  logic [15:0]      stat_proto_err;

  xge_rx_pkt_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .clk_156m25      (clk_156m25),
    .reset_156m25_n  (reset_156m25_n),
    .pkt_rx_avail    (pkt_rx_avail),
    .pkt_rx_data     (pkt_rx_data),
    .pkt_rx_sop      (pkt_rx_sop),
    .pkt_rx_eop      (pkt_rx_eop),
    .pkt_rx_val      (pkt_rx_val),
    .pkt_rx_err      (pkt_rx_err),
    .pkt_rx_mod      (pkt_rx_mod),
    .pkt_rx_ren      (pkt_rx_ren),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_sop         (out_sop),
    .out_eop         (out_eop),
    .out_mod         (out_mod),
    .out_err         (out_err),
    .out_len         (out_len),
    .clear_stats     (clear_stats),
    .stat_frames     (stat_frames),
    .stat_err_frames (stat_err_frames),
    .stat_bytes      (stat_bytes),
    .stat_proto_err  (stat_proto_err)
  );

  // ---------------- clock ----------------
  always #5 clk_156m25 = ~clk_156m25;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  typedef struct {
    bit          raw;
    logic [63:0] data;
    bit          sop;
    bit          eop;
    logic [2:0]  mod;
    bit          err;
  } mac_word_t;

  typedef struct {
    int         nwords;
    logic [2:0] mod;
    bit         err;
    int         exp_len;
    bit         exp_err;
  } vec_t;

  mac_word_t        mac_q[$];
  logic [EW-1:0]    exp_q[$];
  int               n_vec = 0;
  int               n_miss = 0;
  int               n_presented = 0;
  int               ready_mode = 1;
  logic [LEN_W-1:0] last_len = '0;
  logic             last_err = 1'b0;

  bit               m_in_frame = 1'b0;
  int               m_cnt = 0;
  logic [31:0]      exp_frames = '0;
  logic [31:0]      exp_err_frames = '0;
  logic [31:0]      exp_bytes = '0;
  logic [15:0]      exp_proto = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic proto_bump();
    if (exp_proto != 16'hFFFF) exp_proto = exp_proto + 16'd1;
  endtask

  // Reference model: every queued word is eventually presented in order, so the
  // expected output and statistics follow directly from the word stream.
  task automatic push_word(input bit raw, input logic [63:0] data, input bit sop, input bit eop,
                           input logic [2:0] mod, input bit err);
    bit               keep;
    int               len;
    logic [2:0]       mod_f;
    bit               err_f;
    logic [LEN_W-1:0] len_f;
    mac_word_t        w;
    w = '{raw: raw, data: data, sop: sop, eop: eop, mod: mod, err: err};
    mac_q.push_back(w);
    keep = 1'b0;
    if (sop) begin
      if (m_in_frame) proto_bump();
      m_cnt = 1;
      keep  = 1'b1;
    end else if (m_in_frame) begin
      m_cnt++;
      keep = 1'b1;
    end else begin
      proto_bump();
    end
    if (keep) begin
      mod_f = 3'd0;
      err_f = 1'b0;
      len_f = '0;
      if (eop) begin
        len = 8 * (m_cnt - 1) + ((mod == 3'd0) ? 8 : int'(mod));
        if (len > (1 << LEN_W) - 1) len = (1 << LEN_W) - 1;
        len_f          = LEN_W'(len);
        mod_f          = mod;
        err_f          = err;
        m_in_frame     = 1'b0;
        exp_frames     = exp_frames + 32'd1;
        exp_bytes      = exp_bytes + 32'(len);
        if (err) exp_err_frames = exp_err_frames + 32'd1;
      end else begin
        m_in_frame = 1'b1;
      end
      exp_q.push_back({data, sop, eop, mod_f, err_f, len_f});
    end
  endtask

  task automatic push_frame(input int nwords, input logic [2:0] mod, input bit err, input bit with_eop);
    bit last;
    for (int i = 0; i < nwords; i++) begin
      last = (i == nwords - 1) && with_eop;
      push_word(1'b0, {$urandom, $urandom}, (i == 0), last,
                last ? mod : 3'($urandom_range(0, 7)),
                last ? err : 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic model_zero_stats();
    exp_frames     = '0;
    exp_err_frames = '0;
    exp_bytes      = '0;
    exp_proto      = '0;
  endtask

  // ---------------- drivers ----------------
  task automatic mac_drive();
    mac_word_t w;
    forever begin
      @(posedge clk_156m25);
      #1;
      pkt_rx_val  = 1'b0;
      pkt_rx_sop  = 1'b0;
      pkt_rx_eop  = 1'b0;
      pkt_rx_err  = 1'b0;
      pkt_rx_mod  = 3'd0;
      pkt_rx_data = '0;
      if (mac_q.size() != 0 && (mac_q[0].raw || pkt_rx_ren)) begin
        w = mac_q.pop_front();
        pkt_rx_val  = 1'b1;
        pkt_rx_sop  = w.sop;
        pkt_rx_eop  = w.eop;
        pkt_rx_err  = w.err;
        pkt_rx_mod  = w.mod;
        pkt_rx_data = w.data;
        n_presented++;
      end
      pkt_rx_avail = (mac_q.size() != 0);
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic mon_loop();
    logic [EW-1:0] act;
    forever begin
      @(negedge clk_156m25);
      if (reset_156m25_n && out_valid && out_ready) begin
        act = {out_data, out_sop, out_eop, out_mod, out_err, out_len};
        if (exp_q.size() == 0) check("unexpected_word", act, '0);
        else check("out_word", act, exp_q.pop_front());
        if (out_eop) begin
          last_len = out_len;
          last_err = out_err;
        end
      end
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((mac_q.size() != 0 || exp_q.size() != 0) && c < 3000) begin
      @(posedge clk_156m25);
      c++;
    end
    check("drain_done", (mac_q.size() != 0 || exp_q.size() != 0), 0);
    repeat (3) @(posedge clk_156m25);
    @(negedge clk_156m25);
  endtask

  task automatic check_stats();
    check("stat_frames", stat_frames, exp_frames);
    check("stat_err_frames", stat_err_frames, exp_err_frames);
    check("stat_bytes", stat_bytes, exp_bytes);
    check("stat_proto_err", stat_proto_err, exp_proto);
  endtask

  task automatic pulse_clear();
    @(negedge clk_156m25);
    clear_stats = 1'b1;
    @(negedge clk_156m25);
    clear_stats = 1'b0;
    model_zero_stats();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t tbl[6];
    bit   found;
    int   r;

    tbl[0] = '{8, 3'd0, 1'b0, 64, 1'b0};
    tbl[1] = '{8, 3'd5, 1'b1, 61, 1'b1};
    tbl[2] = '{1, 3'd3, 1'b0,  3, 1'b0};
    tbl[3] = '{2, 3'd0, 1'b0, 16, 1'b0};
    tbl[4] = '{3, 3'd1, 1'b0, 17, 1'b0};
    tbl[5] = '{5, 3'd7, 1'b1, 39, 1'b1};

    fork
      mac_drive();
      mon_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clk_156m25);
    @(negedge clk_156m25);
    check("rst_ren", pkt_rx_ren, 0);
    check("rst_valid", out_valid, 0);
    check("rst_fields", {out_data, out_sop, out_eop, out_mod, out_err, out_len}, 0);
    check("rst_stats", {stat_frames, stat_err_frames, stat_bytes, stat_proto_err}, 0);
    reset_156m25_n = 1'b1;

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      push_frame(tbl[i].nwords, tbl[i].mod, tbl[i].err, 1'b1);
      drain();
      check("tbl_len", last_len, tbl[i].exp_len);
      check("tbl_err", last_err, tbl[i].exp_err);
      check_stats();
    end

    // Clear while idle, then back-to-back 1-word and 2-word frames
    pulse_clear();
    @(negedge clk_156m25);
    check("clear_idle", {stat_frames, stat_err_frames, stat_bytes, stat_proto_err}, 0);
    push_frame(1, 3'd3, 1'b0, 1'b1);
    push_frame(2, 3'd0, 1'b0, 1'b1);
    drain();
    check("b2b_frames", stat_frames, 2);
    check("b2b_bytes", stat_bytes, 19);
    check("b2b_last_len", last_len, 16);

    // Consumer stalled through a 20-word frame
    pulse_clear();
    ready_mode  = 0;
    n_presented = 0;
    push_frame(20, 3'd0, 1'b0, 1'b1);
    repeat (30) @(posedge clk_156m25);
    @(negedge clk_156m25);
    check("stall_words_in", n_presented, FIFO_DEPTH);
    check("stall_ren", pkt_rx_ren, 0);
    check("stall_valid", out_valid, 1);
    check("stall_frames", stat_frames, 0);
    ready_mode = 1;
    drain();
    check("stall_len", last_len, 160);
    check_stats();

    // Stray word while idle, then sop inside an open frame
    pulse_clear();
    push_word(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 3'd0, 1'b0);
    push_frame(2, 3'd0, 1'b0, 1'b0);
    push_frame(3, 3'd0, 1'b0, 1'b1);
    drain();
    check("proto_cnt", stat_proto_err, 2);
    check("proto_len", last_len, 24);
    check("proto_frames", stat_frames, 1);

    // Reset in the middle of a frame
    ready_mode = 0;
    push_frame(10, 3'd0, 1'b0, 1'b1);
    repeat (5) @(posedge clk_156m25);
    @(negedge clk_156m25);
    reset_156m25_n = 1'b0;
    mac_q.delete();
    #1;
    check("midrst_ren", pkt_rx_ren, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_fields", {out_data, out_sop, out_eop, out_mod, out_err, out_len}, 0);
    check("midrst_stats", {stat_frames, stat_err_frames, stat_bytes, stat_proto_err}, 0);
    exp_q.delete();
    m_in_frame = 1'b0;
    m_cnt      = 0;
    model_zero_stats();
    repeat (2) @(negedge clk_156m25);
    reset_156m25_n = 1'b1;

    // clear_stats in the same cycle as an eop word
    ready_mode = 1;
    push_frame(3, 3'd2, 1'b1, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_156m25);
      #2;
      if (pkt_rx_val && pkt_rx_eop) begin
        clear_stats = 1'b1;
        found = 1'b1;
        break;
      end
    end
    check("clr_eop_seen", found, 1);
    @(posedge clk_156m25);
    #2;
    clear_stats = 1'b0;
    model_zero_stats();
    drain();
    check("clr_eop_len", last_len, 18);
    check_stats();

    // Randomized frames with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15 && !m_in_frame)
        push_word(1'b1, {$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      else
        push_frame($urandom_range(1, 12), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) != 0));
    end
    if (m_in_frame) push_frame(2, 3'd4, 1'b0, 1'b1);
    drain();
    ready_mode = 1;
    drain();
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
